pe_op_sequencer: RTL and testbench

- Hardware sequencer that queues PE-core instructions and issues them one at a time to the PE core over a start/done handshake.
- Measures the latency of each operation, enforces a timeout, and returns one response per command.
- Replaces fixed-delay host sequencing of MAC/activation/normalisation op chains, e.g. transformer flows.
- Sits between the control host and the PE core's start/instruction/done interface.

---
 rtl/pe_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pe_op_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_op_sequencer.sv
// pe_op_sequencer: queues PE instructions and issues them one at a time over start/done, with latency timing and timeout.
// Define PE_OP_SEQ_PERF_CNT_EN to add saturating perf_ops/perf_timeouts/perf_busy_cycles outputs.
module pe_op_sequencer #(
  parameter int INSTR_WIDTH    = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CYC_WIDTH      = 16,
  parameter int OPC_MSB        = 31,
  parameter int OPC_LSB        = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [INSTR_WIDTH-1:0]   cmd_instr,
  input  logic                     flush,
  output logic                     pe_start,
  output logic [INSTR_WIDTH-1:0]   pe_instruction,
  input  logic                     pe_done,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [1:0]               resp_status,
  output logic [OPC_MSB-OPC_LSB:0] resp_opcode,
  output logic [CYC_WIDTH-1:0]     resp_cycles,
  output logic                     busy,
  output logic                     err_spurious_done
`ifdef PE_OP_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]              perf_ops,
  output logic [15:0]              perf_timeouts,
  output logic [31:0]              perf_busy_cycles
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] ST_OK = 2'd0, ST_TO = 2'd1, ST_ABORT = 2'd2;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                   r_state;
  logic [INSTR_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]            r_wp, r_rp;
  logic [CW-1:0]            r_count;
  logic [INSTR_WIDTH-1:0]   r_instr;
  logic [CYC_WIDTH-1:0]     r_cyc, r_cycles;
  logic [OPC_MSB-OPC_LSB:0] r_opc;
  logic [1:0]               r_status;
  logic                     r_pe_start, r_resp_valid, r_spur, r_grace;
  logic                     w_push, w_pop, w_full, w_empty, w_nop, w_to;
  logic [INSTR_WIDTH-1:0]   w_head;
  logic [CYC_WIDTH-1:0]     w_cyc_inc;
  // depth is a power of two, so the occupancy MSB alone marks full
  assign w_full    = r_count[PW];
  assign w_empty   = r_count == '0;
  assign cmd_ready = rst_n & ~w_full & ~flush;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_pop     = (r_state == IDLE) & ~w_empty & ~flush;
  assign w_head    = r_mem[r_rp];
  assign w_nop     = w_head[OPC_MSB:OPC_LSB] == '0;
  assign w_cyc_inc = r_cyc + CYC_WIDTH'(1);
  assign w_to      = w_cyc_inc == CYC_WIDTH'(TIMEOUT_CYCLES);
  assign busy              = (r_state != IDLE) | ~w_empty;
  assign pe_start          = r_pe_start;
  assign pe_instruction    = r_instr;
  assign resp_valid        = r_resp_valid;
  assign resp_status       = r_status;
  assign resp_opcode       = r_opc;
  assign resp_cycles       = r_cycles;
  assign err_spurious_done = r_spur;
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= cmd_instr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= w_push ? r_wp + PW'(1) : r_wp;
      r_rp    <= w_pop ? r_rp + PW'(1) : r_rp;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_instr      <= '0;
      r_cyc        <= '0;
      r_cycles     <= '0;
      r_opc        <= '0;
      r_status     <= ST_OK;
      r_pe_start   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_spur       <= 1'b0;
      r_grace      <= 1'b0;
    end else begin
      r_pe_start <= 1'b0;
      r_grace    <= 1'b0;
      r_spur     <= flush ? 1'b0 : r_spur | (pe_done & (r_state != WAIT) & ~r_grace);
      case (r_state)
        IDLE: if (w_pop) begin
          r_opc <= w_head[OPC_MSB:OPC_LSB];
          r_cyc <= '0;
          if (w_nop) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_status     <= ST_OK;
            r_cycles     <= '0;
          end else begin
            r_state    <= ISSUE;
            r_instr    <= w_head;
            r_pe_start <= 1'b1;
          end
        end
        ISSUE: if (flush) begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_status     <= ST_ABORT;
          r_cycles     <= r_cyc;
          r_grace      <= 1'b1;
        end else r_state <= WAIT;
        WAIT: begin
          r_cyc <= w_cyc_inc;
          if (flush || pe_done || w_to) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_status     <= flush ? ST_ABORT : pe_done ? ST_OK : ST_TO;
            r_cycles     <= w_cyc_inc;
            r_grace      <= flush;
          end
        end
        RESP: if (resp_ready) begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef PE_OP_SEQ_PERF_CNT_EN
  logic        w_ok_evt, w_to_evt, w_active;
  logic [31:0] r_ops, r_busy_cyc;
  logic [15:0] r_tos;
  assign w_ok_evt = (w_pop & w_nop) | ((r_state == WAIT) & ~flush & pe_done);
  assign w_to_evt = (r_state == WAIT) & ~flush & ~pe_done & w_to;
  assign w_active = (r_state == ISSUE) | (r_state == WAIT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops      <= '0;
      r_tos      <= '0;
      r_busy_cyc <= '0;
    end else begin
      r_ops      <= (w_ok_evt && !(&r_ops)) ? r_ops + 32'd1 : r_ops;
      r_tos      <= (w_to_evt && !(&r_tos)) ? r_tos + 16'd1 : r_tos;
      r_busy_cyc <= (w_active && !(&r_busy_cyc)) ? r_busy_cyc + 32'd1 : r_busy_cyc;
    end
  end
  assign perf_ops         = r_ops;
  assign perf_timeouts    = r_tos;
  assign perf_busy_cycles = r_busy_cyc;
`endif
endmodule

// File: tb/tb_pe_op_sequencer.sv
// tb_pe_op_sequencer: directed stimulus against a transaction-level response model plus literal checks.
// Instruction bits [7:0] tell the PE model in which WAIT cycle to raise done (0 = never).
module tb_pe_op_sequencer;
  localparam int TO = 8;
  typedef struct packed {
    logic [1:0]  st;
    logic [3:0]  opc;
    logic [15:0] cy;
    logic [31:0] instr;
  } exp_t;
  logic        clk = 0, rst_n = 0, cmd_valid = 0, flush = 0, pe_done = 0, resp_ready = 1, force_done = 0;
  logic [31:0] cmd_instr = 0;
  logic        cmd_ready, pe_start, resp_valid, busy, err_spurious_done;
  logic [31:0] pe_instruction;
  logic [1:0]  resp_status;
  logic [3:0]  resp_opcode;
  logic [15:0] resp_cycles;
  int n_tests = 0, n_fail = 0, cyc = 0, done_at = -1, n_starts = 0;
  exp_t q[$];
  logic [31:0] vals [4];
  pe_op_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
    .flush(flush), .pe_start(pe_start), .pe_instruction(pe_instruction), .pe_done(pe_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_opcode(resp_opcode), .resp_cycles(resp_cycles), .busy(busy),
    .err_spurious_done(err_spurious_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic miss(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask
  function automatic exp_t predict(input logic [31:0] ins);
    exp_t e;
    int k;
    k = int'(ins[7:0]);
    e.instr = ins;
    e.opc = ins[31:28];
    e.st = 2'd0;
    e.cy = 16'(k);
    if (e.opc == 4'd0) e.cy = 16'd0;
    else if (k == 0 || k > TO) begin
      e.st = 2'd1;
      e.cy = 16'(TO);
    end
    return e;
  endfunction
  // PE model: raise done in the requested WAIT cycle, or on a forced pulse
  always begin
    @(posedge clk);
    #2;
    pe_done = force_done | (cyc == done_at);
  end
  // Compare process: response order/content, issue content, hold stability, flush effects
  logic        inflight = 0, held = 0;
  int          start_cyc = 0;
  logic [1:0]  h_st;
  logic [3:0]  h_opc;
  logic [15:0] h_cy;
  exp_t        e;
  always @(negedge clk) if (rst_n) begin
    if (held && resp_valid) begin
      chk("hold_status", 32'(resp_status), 32'(h_st));
      chk("hold_opcode", 32'(resp_opcode), 32'(h_opc));
      chk("hold_cycles", 32'(resp_cycles), 32'(h_cy));
    end
    if (resp_valid) begin
      chk("no_start_in_resp", 32'(pe_start), 0);
      inflight = 0;
    end
    if (pe_start) begin
      n_starts++;
      if (q.size() == 0) miss("start_expected_cmd");
      else begin
        chk("start_instr", pe_instruction, q[0].instr);
        inflight = 1;
        start_cyc = cyc;
        done_at = (q[0].instr[7:0] == 8'd0) ? -1 : cyc + int'(q[0].instr[7:0]);
      end
    end
    if (flush) begin
      if (resp_valid) begin
        while (q.size() > 1) void'(q.pop_back());
      end else if (inflight && q.size() > 0) begin
        e = q[0];
        e.st = 2'd2;
        e.cy = 16'(cyc - start_cyc);
        q.delete();
        q.push_back(e);
        inflight = 0;
        done_at = -1;
      end else q.delete();
    end
    if (resp_valid && resp_ready) begin
      if (q.size() == 0) miss("resp_expected_cmd");
      else begin
        e = q.pop_front();
        chk("resp_status", 32'(resp_status), 32'(e.st));
        chk("resp_opcode", 32'(resp_opcode), 32'(e.opc));
        chk("resp_cycles", 32'(resp_cycles), 32'(e.cy));
      end
      held = 0;
    end else if (resp_valid) begin
      held = 1;
      h_st = resp_status;
      h_opc = resp_opcode;
      h_cy = resp_cycles;
    end
    if (cmd_valid && cmd_ready) q.push_back(predict(cmd_instr));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] ins);
    step();
    cmd_valid = 1;
    cmd_instr = ins;
    step();
    cmd_valid = 0;
  endtask
  task automatic wait_resp(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 100);
    if (!resp_valid) miss(nm);
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) miss(nm);
  endtask
  initial begin
    int n0, s0, n;
    vals[0] = 32'h1000_0001;
    vals[1] = 32'h2000_0002;
    vals[2] = 32'h3000_0004;
    vals[3] = 32'h0000_0000;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_pe_start", 32'(pe_start), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_spurious_done), 0);
    chk("rst_instr", pe_instruction, 0);
    step();
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    // single op, done in 3rd WAIT cycle
    step();
    cmd_valid = 1;
    cmd_instr = 32'h1000_0003;
    n0 = cyc;
    step();
    cmd_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pe_start && n < 20);
    if (!pe_start) miss("t1_start");
    else chk("t1_start_latency", cyc - n0, 2);
    wait_resp("t1_resp");
    chk("t1_status", 32'(resp_status), 0);
    chk("t1_opcode", 32'(resp_opcode), 1);
    chk("t1_cycles", 32'(resp_cycles), 3);
    chk("t1_instr", pe_instruction, 32'h1000_0003);
    wait_idle("t1_idle");
    // fill the FIFO behind a long op, then a rejected 5th push
    s0 = n_starts;
    step();
    cmd_valid = 1;
    cmd_instr = 32'h5000_0008;
    for (int i = 0; i < 4; i++) begin
      step();
      cmd_instr = vals[i];
    end
    step();
    cmd_instr = 32'h6000_0001;
    @(negedge clk);
    chk("t2_full_ready", 32'(cmd_ready), 0);
    chk("t2_busy", 32'(busy), 1);
    step();
    cmd_valid = 0;
    wait_idle("t2_idle");
    chk("t2_starts", n_starts - s0, 4);
    chk("t2_instr_kept", pe_instruction, 32'h3000_0004);
    // timeout, then a normal op
    push(32'h7000_0000);
    wait_resp("t3_resp");
    chk("t3_status", 32'(resp_status), 1);
    chk("t3_cycles", 32'(resp_cycles), TO);
    chk("t3_opcode", 32'(resp_opcode), 7);
    push(32'h1000_0002);
    wait_resp("t3b_resp");
    chk("t3b_status", 32'(resp_status), 0);
    chk("t3b_cycles", 32'(resp_cycles), 2);
    // done coincides with the timeout cycle
    push(32'h2000_0008);
    wait_resp("t4_resp");
    chk("t4_status", 32'(resp_status), 0);
    chk("t4_cycles", 32'(resp_cycles), TO);
    wait_idle("t4_idle");
    // flush in 2nd WAIT cycle with 2 queued
    resp_ready = 0;
    step();
    cmd_valid = 1;
    cmd_instr = 32'h3000_0000;
    step();
    cmd_instr = 32'h1000_0001;
    step();
    cmd_instr = 32'h2000_0001;
    step();
    cmd_valid = 0;
    step();
    flush = 1;
    step();
    flush = 0;
    wait_resp("t5_resp");
    chk("t5_status", 32'(resp_status), 2);
    chk("t5_cycles", 32'(resp_cycles), 2);
    step();
    resp_ready = 1;
    step();
    @(negedge clk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_resp_valid", 32'(resp_valid), 0);
    // spurious done in IDLE, then a held response
    step();
    force_done = 1;
    step();
    force_done = 0;
    @(negedge clk);
    chk("t6_err_set", 32'(err_spurious_done), 1);
    resp_ready = 0;
    push(32'h4000_0002);
    wait_resp("t6_resp");
    chk("t6_opcode", 32'(resp_opcode), 4);
    chk("t6_cycles", 32'(resp_cycles), 2);
    push(32'h1000_0001);
    repeat (5) @(negedge clk);
    chk("t6_still_valid", 32'(resp_valid), 1);
    chk("t6_err_sticky", 32'(err_spurious_done), 1);
    step();
    resp_ready = 1;
    wait_idle("t6_idle");
    chk("t6_err_after", 32'(err_spurious_done), 1);
    step();
    flush = 1;
    step();
    flush = 0;
    @(negedge clk);
    chk("t6_err_cleared", 32'(err_spurious_done), 0);
    repeat (3) @(negedge clk);
    chk("model_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
